// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg : shared state encoding and unit-timing constants for the keyer
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package morse_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_MARK  = 3'd2,
        S_EGAP  = 3'd3,
        S_CGAP  = 3'd4,
        S_WORD  = 3'd5
    } state_t;

    localparam logic [5:0] CODE_SPACE     = 6'd36;
    localparam logic [5:0] CODE_MAX_VALID = 6'd36;

    localparam int MAX_LEN          = 5;
    localparam int DASH_UNITS       = 3;
    localparam int CGAP_UNITS       = 3;
    localparam int WORD_EXTRA_UNITS = 4;

    // Counter loads: a state lasts (load + 1) units, and the tick that ends a
    // mark already counts as the first unit of the following gap.
    localparam logic [1:0] UCNT_DASH = 2'(DASH_UNITS - 1);
    localparam logic [1:0] UCNT_CGAP = 2'(CGAP_UNITS - 2);
    localparam logic [1:0] UCNT_WORD = 2'(WORD_EXTRA_UNITS - 1);

    function automatic logic [1:0] mark_load(input logic is_dash);
        return is_dash ? UCNT_DASH : 2'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/morse_rom.sv
// ---------------------------------------------------------------------------
// morse_rom : combinational code -> {valid, len, pat} table (ITU Morse)
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0]         char_code,
    output logic               valid,
    output logic [2:0]         len,
    output logic [MAX_LEN-1:0] pat
);

    // pat[0] is the first element sent; 1 = dash, 0 = dot.
    always_comb begin
        valid = (char_code <= CODE_MAX_VALID);
        len   = 3'd0;
        pat   = '0;
        case (char_code)
            6'd0:  {len, pat} = {3'd2, 5'b00010}; // A
            6'd1:  {len, pat} = {3'd4, 5'b00001}; // B
            6'd2:  {len, pat} = {3'd4, 5'b00101}; // C
            6'd3:  {len, pat} = {3'd3, 5'b00001}; // D
            6'd4:  {len, pat} = {3'd1, 5'b00000}; // E
            6'd5:  {len, pat} = {3'd4, 5'b00100}; // F
            6'd6:  {len, pat} = {3'd3, 5'b00011}; // G
            6'd7:  {len, pat} = {3'd4, 5'b00000}; // H
            6'd8:  {len, pat} = {3'd2, 5'b00000}; // I
            6'd9:  {len, pat} = {3'd4, 5'b01110}; // J
            6'd10: {len, pat} = {3'd3, 5'b00101}; // K
            6'd11: {len, pat} = {3'd4, 5'b00010}; // L
            6'd12: {len, pat} = {3'd2, 5'b00011}; // M
            6'd13: {len, pat} = {3'd2, 5'b00001}; // N
            6'd14: {len, pat} = {3'd3, 5'b00111}; // O
            6'd15: {len, pat} = {3'd4, 5'b00110}; // P
            6'd16: {len, pat} = {3'd4, 5'b01011}; // Q
            6'd17: {len, pat} = {3'd3, 5'b00010}; // R
            6'd18: {len, pat} = {3'd3, 5'b00000}; // S
            6'd19: {len, pat} = {3'd1, 5'b00001}; // T
            6'd20: {len, pat} = {3'd3, 5'b00100}; // U
            6'd21: {len, pat} = {3'd4, 5'b01000}; // V
            6'd22: {len, pat} = {3'd3, 5'b00110}; // W
            6'd23: {len, pat} = {3'd4, 5'b01001}; // X
            6'd24: {len, pat} = {3'd4, 5'b01101}; // Y
            6'd25: {len, pat} = {3'd4, 5'b00011}; // Z
            6'd26: {len, pat} = {3'd5, 5'b11111}; // 0
            6'd27: {len, pat} = {3'd5, 5'b11110}; // 1
            6'd28: {len, pat} = {3'd5, 5'b11100}; // 2
            6'd29: {len, pat} = {3'd5, 5'b11000}; // 3
            6'd30: {len, pat} = {3'd5, 5'b10000}; // 4
            6'd31: {len, pat} = {3'd5, 5'b00000}; // 5
            6'd32: {len, pat} = {3'd5, 5'b00001}; // 6
            6'd33: {len, pat} = {3'd5, 5'b00011}; // 7
            6'd34: {len, pat} = {3'd5, 5'b00111}; // 8
            6'd35: {len, pat} = {3'd5, 5'b01111}; // 9
            default: {len, pat} = {3'd0, 5'b00000};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/morse_keyer.sv
// ---------------------------------------------------------------------------
// morse_keyer : one character per valid/ready transfer, keyed with Morse timing
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module morse_keyer
    import morse_pkg::*;
#(
    parameter logic KEY_ACTIVE = 1'b1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick,
    input  logic       char_valid,
    input  logic [5:0] char_code,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err
);

    state_t               state, state_nxt;
    logic [MAX_LEN-1:0]   pat_sr, pat_nxt;
    logic [2:0]           ecnt, ecnt_nxt;
    logic [1:0]           ucnt, ucnt_nxt;
    logic                 key_nxt, err_nxt;
    logic                 accept;
    logic                 rom_valid;
    logic [2:0]           rom_len;
    logic [MAX_LEN-1:0]   rom_pat;

    morse_rom u_rom (
        .char_code (char_code),
        .valid     (rom_valid),
        .len       (rom_len),
        .pat       (rom_pat)
    );

    assign char_ready = (state == S_IDLE) && !reset;
    assign busy       = (state != S_IDLE);
    assign accept     = char_valid && char_ready;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pat_sr  <= '0;
            ecnt    <= 3'd0;
            ucnt    <= 2'd0;
            key_out <= ~KEY_ACTIVE;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pat_sr  <= pat_nxt;
            ecnt    <= ecnt_nxt;
            ucnt    <= ucnt_nxt;
            key_out <= key_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_sr;
        ecnt_nxt  = ecnt;
        ucnt_nxt  = ucnt;
        key_nxt   = key_out;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                // Ticks are ignored here so a tick on the accept edge never counts.
                if (accept) begin
                    if (char_code == CODE_SPACE) begin
                        ucnt_nxt  = UCNT_WORD;
                        state_nxt = S_WORD;
                    end else if (rom_valid) begin
                        pat_nxt   = rom_pat;
                        ecnt_nxt  = rom_len;
                        state_nxt = S_ALIGN;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
            end
            S_ALIGN, S_EGAP: begin
                if (tick) begin
                    key_nxt   = KEY_ACTIVE;
                    ucnt_nxt  = mark_load(pat_sr[0]);
                    state_nxt = S_MARK;
                end
            end
            S_MARK: begin
                if (tick) begin
                    if (ucnt == 2'd0) begin
                        key_nxt  = ~KEY_ACTIVE;
                        pat_nxt  = pat_sr >> 1;
                        ecnt_nxt = (ecnt != 3'd0) ? ecnt - 3'd1 : 3'd0;
                        if (ecnt > 3'd1) begin
                            state_nxt = S_EGAP;
                        end else begin
                            ucnt_nxt  = UCNT_CGAP;
                            state_nxt = S_CGAP;
                        end
                    end else begin
                        ucnt_nxt = ucnt - 2'd1;
                    end
                end
            end
            S_CGAP, S_WORD: begin
                if (tick) begin
                    if (ucnt == 2'd0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        ucnt_nxt = ucnt - 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                key_nxt   = ~KEY_ACTIVE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_morse_keyer.sv
// ---------------------------------------------------------------------------
// tb_morse_keyer : directed table and sequence checks for morse_keyer
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_morse_keyer;

    logic       clk_in     = 1'b0;
    logic       reset      = 1'b1;
    logic       tick       = 1'b0;
    logic       char_valid = 1'b0;
    logic [5:0] char_code  = 6'd0;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       err;

    int applied     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [5:0]  code;
        logic [39:0] sym;   // five ASCII chars, '-', '.' or padding space
    } vec_t;

    vec_t tab [16];

    morse_keyer #(.KEY_ACTIVE(1'b1)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .tick       (tick),
        .char_valid (char_valid),
        .char_code  (char_code),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_s(input string name, input string act, input string exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got key units %s, expected %s", name, act, exp);
        end
    endtask

    // Inputs change after a falling edge; outputs are read at the next falling edge.
    task automatic step(input logic t);
        tick = t;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Key level per unit: each element is its on-time then one off unit,
    // and the character gap adds two more off units.
    function automatic string expand(input logic [39:0] sym);
        string s;
        logic [7:0] c;
        s = "";
        for (int i = 4; i >= 0; i--) begin
            c = sym[i*8 +: 8];
            if (c == 8'h2D) s = {s, "1110"};
            else if (c == 8'h2E) s = {s, "10"};
        end
        return {s, "00"};
    endfunction

    // Presents up to three codes as soon as char_ready is seen, ticks every tp
    // cycles, and records key_out after every tick edge following the first accept.
    task automatic run_seq(input string name, input logic [17:0] codes, input int n,
                           input int tp, input string exp);
        string s;
        int    idx;
        int    cnt;
        bit    rec;
        bit    acc;
        bit    t;
        s = ""; idx = 0; cnt = 0; rec = 0;
        for (int c = 0; c < 400; c++) begin
            acc        = char_ready && (idx < n);
            char_valid = acc;
            char_code  = acc ? codes[idx*6 +: 6] : 6'd0;
            t          = ((cnt % tp) == tp - 1);
            cnt++;
            step(t);
            if (t && rec) begin
                if (key_out) s = {s, "1"};
                else         s = {s, "0"};
            end
            if (acc) begin
                idx++;
                rec = 1;
            end
            if (idx == n && !busy) break;
        end
        char_valid = 1'b0;
        tick       = 1'b0;
        check_s(name, s, exp);
    endtask

    initial begin
        string s;
        int    high_cnt;
        int    rise_at;
        int    fall_at;
        bit    err_seen;

        tab[0]  = '{code: 6'd0,  sym: ".-   "};
        tab[1]  = '{code: 6'd1,  sym: "-... "};
        tab[2]  = '{code: 6'd2,  sym: "-.-. "};
        tab[3]  = '{code: 6'd4,  sym: ".    "};
        tab[4]  = '{code: 6'd9,  sym: ".--- "};
        tab[5]  = '{code: 6'd10, sym: "-.-  "};
        tab[6]  = '{code: 6'd15, sym: ".--. "};
        tab[7]  = '{code: 6'd16, sym: "--.- "};
        tab[8]  = '{code: 6'd19, sym: "-    "};
        tab[9]  = '{code: 6'd23, sym: "-..- "};
        tab[10] = '{code: 6'd24, sym: "-.-- "};
        tab[11] = '{code: 6'd25, sym: "--.. "};
        tab[12] = '{code: 6'd26, sym: "-----"};
        tab[13] = '{code: 6'd27, sym: ".----"};
        tab[14] = '{code: 6'd31, sym: "....."};
        tab[15] = '{code: 6'd35, sym: "----."};

        // Reset state
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_key",   32'(key_out),    32'd0);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_err",   32'(err),        32'd0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", 32'(char_ready), 32'd1);
        @(negedge clk_in);

        // Table: tick every cycle, including a coincident tick on the accept edge
        for (int i = 0; i < 16; i++) begin
            s          = "";
            char_code  = tab[i].code;
            char_valid = 1'b1;
            step(1'b1);
            char_valid = 1'b0;
            check($sformatf("accept_hs_code%0d", tab[i].code), 32'({char_ready, busy, key_out}), 32'd2);
            for (int c = 0; c < 40; c++) begin
                step(1'b1);
                if (key_out) s = {s, "1"};
                else         s = {s, "0"};
                if (!busy) break;
            end
            check_s($sformatf("table_code%0d", tab[i].code), s, expand(tab[i].sym));
        end
        tick = 1'b0;

        // E with ticks every 10 cycles; accept edge carries a tick
        char_code  = 6'd4;
        char_valid = 1'b1;
        step(1'b1);
        char_valid = 1'b0;
        high_cnt = 0; rise_at = -1; fall_at = -1;
        for (int c = 1; c <= 80; c++) begin
            step((c % 10) == 0);
            if (key_out) begin
                high_cnt++;
                if (rise_at < 0) rise_at = c;
            end
            if (!busy) begin
                fall_at = c;
                break;
            end
        end
        tick = 1'b0;
        check("e_slow_high_cycles", 32'(high_cnt), 32'd10);
        check("e_slow_rise_cycle",  32'(rise_at),  32'd10);
        check("e_slow_busy_fall",   32'(fall_at),  32'd40);

        // Back-to-back characters and word space
        run_seq("seq_A_T",   {6'd0, 6'd19, 6'd0},  2, 4, "10111000111000");
        run_seq("seq_digit0", {6'd0, 6'd0, 6'd26}, 1, 3, "1110111011101110111000");
        run_seq("seq_E_sp_E", {6'd4, 6'd36, 6'd4}, 3, 2, "100000001000");

        // Invalid code in IDLE
        char_code  = 6'd45;
        char_valid = 1'b1;
        step(1'b0);
        char_valid = 1'b0;
        check("inv_err",   32'(err),        32'd1);
        check("inv_key",   32'(key_out),    32'd0);
        check("inv_ready", 32'(char_ready), 32'd1);
        step(1'b0);
        check("inv_err_pulse_end", 32'(err), 32'd0);

        // char_valid held with an invalid code while busy has no effect
        char_code  = 6'd4;
        char_valid = 1'b1;
        step(1'b0);
        char_code = 6'd45;
        err_seen  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b1);
            err_seen |= err;
        end
        check("held_valid_busy", 32'({err_seen, busy}), 32'd1);
        step(1'b1);
        step(1'b0);
        check("held_valid_idle_err", 32'(err), 32'd1);
        char_valid = 1'b0;
        step(1'b0);

        // Reset during the 2nd unit of B's leading dash
        char_code  = 6'd1;
        char_valid = 1'b1;
        step(1'b0);
        char_valid = 1'b0;
        step(1'b1);
        step(1'b0); step(1'b0); step(1'b0);
        step(1'b1);
        step(1'b0);
        check("b_dash_on", 32'(key_out), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_key_async", 32'(key_out), 32'd0);
        check("mid_rst_state", 32'({busy, char_ready}), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        #1;
        check("mid_rst_release_ready", 32'({char_ready, busy}), 32'd2);
        @(negedge clk_in);
        run_seq("post_rst_E", {6'd0, 6'd0, 6'd4}, 1, 4, "1000");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
